branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Resolution-side counterpart of the global (gshare-style) predictor.
- Holds a FIFO of in-flight predicted branches (PC, predicted direction, GHR snapshot), pushed at fetch.
- Matches each against the execute-stage outcome and drives the predictor update interface (Branch_resolved / Branch_resolved_addr / update index).
- Detects mispredictions, signals flush and restores the corrected GHR; keeps branch/mispredict counters.

Parameters:
- GHR_BITS, 12, global history width; also the PHT index width.
- DEPTH, 4, in-flight branch queue entries; power of two, at least 2.
- CNT_BITS, 32, width of the statistics counters.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- Pred_valid  in  1  fetch pushes a predicted conditional branch this cycle.
- Pred_addr  in  32  PC of the predicted branch.
- Pred_taken  in  1  predicted direction (predictor Taken).
- Pred_ghr  in  GHR_BITS  GHR value used to index the PHT for this prediction.
- Exec_valid  in  1  execute stage resolves a conditional branch this cycle.
- Exec_addr  in  32  PC of the resolving branch.
- Exec_taken  in  1  actual direction.
- Stall  out  1  queue full; fetch must hold Pred_valid.
- Branch_resolved  out  1  actual direction sent to the predictor.
- Branch_resolved_addr  out  32  PC of the resolved branch; 0 = no update this cycle.
- Resolve_valid  out  1  update strobe; authoritative even for PC 0.
- Update_idx  out  GHR_BITS  PHT index to train (snapshot GHR).
- Mispredict  out  1  one-cycle pulse; fetch redirects, younger work flushed.
- Recover_ghr  out  GHR_BITS  {snapshot[GHR_BITS-2:0], Exec_taken}; valid with Mispredict.
- Branch_count  out  CNT_BITS  resolved branches since reset.
- Mispredict_count  out  CNT_BITS  mispredictions since reset.

Behaviour:
- Reset (RESET=0, async):
  - Queue empty, pointers 0, state EMPTY.
  - All outputs 0, counters 0.
  - Stall=0.
- Reset mid-operation discards all entries immediately; no update is emitted for them.
- Queue:
  - Circular buffer, head/tail pointers of log2(DEPTH) bits plus a wrap bit.
  - Full when pointers are equal and wrap bits differ.
  - Stall = full, combinational from state.
  - A push while full is ignored.
  - Push and pop in the same cycle is legal, including when full: the pop frees the slot and the push is accepted.
- Resolution (all outputs registered; update visible the cycle after Exec_valid):
  - Exec_valid with queue non-empty and Exec_addr == head PC:
    - Pop the head.
    - Resolve_valid=1, Branch_resolved=Exec_taken, Branch_resolved_addr=Exec_addr, Update_idx=head GHR.
    - Branch_count increments.
  - If Exec_taken != head predicted direction:
    - Mispredict=1 and Recover_ghr computed as above.
    - Mispredict_count increments.
    - All remaining entries are discarded (younger, wrong path).
    - Enter RECOVER.
  - Exec_valid with queue empty, or with an address mismatch:
    - Treated as a mispredict of an untracked branch.
    - Update emitted with Update_idx=0, Mispredict=1, Recover_ghr={GHR_BITS-1 zeros, Exec_taken}.
    - Queue flushed; enter RECOVER.
  - No Exec_valid: Resolve_valid=0, Branch_resolved_addr=0, Mispredict=0.
- State machine:
  - EMPTY -> ACTIVE on an accepted push.
  - ACTIVE -> EMPTY when the last entry pops correctly with no push.
  - ACTIVE/EMPTY -> RECOVER on Mispredict.
  - RECOVER lasts exactly one cycle; Pred_valid is ignored (wrong-path fetch). Exec_valid in RECOVER is also ignored.
  - RECOVER -> EMPTY.
- Counters wrap modulo 2^CNT_BITS without saturation.
- A pop and a push in the same non-mispredict cycle: the pushed entry is kept.
- A mispredict cycle discards a simultaneous push.

Decomposition:
- Shared package (predictor_pkg) holds:
  - GHR_BITS default.
  - State encoding EMPTY/ACTIVE/RECOVER.
  - Entry struct {addr[31:0], taken, ghr[GHR_BITS-1:0]}.
  - The "addr 0 = no update" convention.
- One sub-module: branch_queue (parameterised circular FIFO with push/pop/flush, full/empty).
- Compare/update logic and counters stay in the top level.

Test Plan:
- Push 0x400 taken ghr=0x0A5; Exec 0x400 taken -> next cycle Resolve_valid=1, addr=0x400, Branch_resolved=1, Update_idx=0x0A5, Mispredict=0, Branch_count=1.
- Push 0x400 taken ghr=0x0A5, push 0x404; Exec 0x400 not-taken -> Mispredict=1, Recover_ghr=0x14A, queue empty (0x404 dropped), Mispredict_count=1, Pred_valid ignored for the one RECOVER cycle.
- Push 4 entries (DEPTH=4) -> Stall=1, 5th push ignored; same-cycle correct Exec of head plus push -> accepted, Stall stays 1.
- Exec 0x500 with empty queue -> Mispredict=1, Update_idx=0, Recover_ghr=0x001 if taken.
- Assert RESET low with 3 entries queued -> queue empty, outputs 0, counters 0, no Resolve_valid after release.
- Push/resolve 2^CNT_BITS branches with CNT_BITS=4 -> Branch_count wraps 15 -> 0.

Source files
------------

// File: rtl/predictor_pkg.sv
// Shared types for the gshare predictor and its resolution side: state
// encoding, in-flight branch record and the "address 0 = no update" marker.
package predictor_pkg;

    localparam int PRED_GHR_BITS = 12;

    // Branch_resolved_addr value meaning "no predictor update this cycle".
    localparam logic [31:0] NO_UPDATE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RECOVER = 2'd2
    } brs_state_t;

    typedef struct packed {
        logic [31:0]              addr;
        logic                     taken;
        logic [PRED_GHR_BITS-1:0] ghr;
    } pred_entry_t;

endpackage

// File: rtl/branch_queue.sv
// Circular FIFO of in-flight branch records. Pointers carry a wrap bit so
// full/empty fall out of a compare; flush drops every entry in one cycle.
module branch_queue #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             last
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] slot_reg [DEPTH];
    logic [AW:0]      head_reg, tail_reg;
    logic [AW:0]      occupancy;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else if (flush) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + (AW+1)'(1);
            if (pop)  head_reg <= head_reg + (AW+1)'(1);
        end
    end

    // Storage needs no reset: an entry is only read once the pointers cover it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge CLK) begin
            if (push && !flush && (tail_reg[AW-1:0] == AW'(gi)))
                slot_reg[gi] <= push_data;
        end
    end

    always_comb begin
        occupancy = tail_reg - head_reg;
        head_data = slot_reg[head_reg[AW-1:0]];
        empty     = (head_reg == tail_reg);
        full      = (head_reg[AW-1:0] == tail_reg[AW-1:0]) && (head_reg[AW] != tail_reg[AW]);
        last      = (occupancy == (AW+1)'(1));
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Matches execute-stage branch outcomes against the in-flight prediction queue,
// trains the PHT, flags mispredictions with the repaired GHR and counts both.
module branch_resolve_unit
    import predictor_pkg::*;
#(
    parameter int GHR_BITS = PRED_GHR_BITS,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Pred_valid,
    input  logic [31:0]         Pred_addr,
    input  logic                Pred_taken,
    input  logic [GHR_BITS-1:0] Pred_ghr,
    input  logic                Exec_valid,
    input  logic [31:0]         Exec_addr,
    input  logic                Exec_taken,
    output logic                Stall,
    output logic                Branch_resolved,
    output logic [31:0]         Branch_resolved_addr,
    output logic                Resolve_valid,
    output logic [GHR_BITS-1:0] Update_idx,
    output logic                Mispredict,
    output logic [GHR_BITS-1:0] Recover_ghr,
    output logic [CNT_BITS-1:0] Branch_count,
    output logic [CNT_BITS-1:0] Mispredict_count
);
    typedef struct packed {
        logic [31:0]         addr;
        logic                taken;
        logic [GHR_BITS-1:0] ghr;
    } entry_t;

    brs_state_t          state_reg, state_next;
    entry_t              push_entry, head_entry;
    logic                q_full, q_empty, q_last;
    logic                q_push, q_pop, q_flush;
    logic                in_recover, exec_act, head_hit, mispredict;
    logic [GHR_BITS-1:0] recover_next;

    logic                resolve_valid_reg, branch_resolved_reg, mispredict_reg;
    logic [31:0]         resolved_addr_reg;
    logic [GHR_BITS-1:0] update_idx_reg, recover_ghr_reg;
    logic [CNT_BITS-1:0] branch_count_reg, mispredict_count_reg;

    branch_queue #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (q_flush),
        .push_data (push_entry),
        .head_data (head_entry),
        .full      (q_full),
        .empty     (q_empty),
        .last      (q_last)
    );

    // RECOVER swallows both ports: anything arriving then is wrong-path.
    always_comb begin
        push_entry = '{addr: Pred_addr, taken: Pred_taken, ghr: Pred_ghr};
        in_recover = (state_reg == ST_RECOVER);
        exec_act   = Exec_valid && !in_recover;
        head_hit   = exec_act && !q_empty && (Exec_addr == head_entry.addr);
        mispredict = exec_act && (!head_hit || (Exec_taken != head_entry.taken));
        q_pop      = head_hit && !mispredict;
        q_flush    = mispredict;
        q_push     = Pred_valid && !in_recover && !mispredict && (!q_full || q_pop);
        if (head_hit)
            recover_next = {head_entry.ghr[GHR_BITS-2:0], Exec_taken};
        else
            recover_next = {{(GHR_BITS-1){1'b0}}, Exec_taken};
    end

    always_comb begin
        state_next = state_reg;
        if (mispredict) begin
            state_next = ST_RECOVER;
        end else begin
            case (state_reg)
                ST_EMPTY:   if (q_push) state_next = ST_ACTIVE;
                ST_ACTIVE:  if (q_pop && q_last && !q_push) state_next = ST_EMPTY;
                ST_RECOVER: state_next = ST_EMPTY;
                default:    state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg            <= ST_EMPTY;
            resolve_valid_reg    <= 1'b0;
            branch_resolved_reg  <= 1'b0;
            resolved_addr_reg    <= NO_UPDATE_ADDR;
            update_idx_reg       <= '0;
            mispredict_reg       <= 1'b0;
            recover_ghr_reg      <= '0;
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            state_reg           <= state_next;
            resolve_valid_reg   <= exec_act;
            branch_resolved_reg <= exec_act && Exec_taken;
            resolved_addr_reg   <= exec_act ? Exec_addr : NO_UPDATE_ADDR;
            update_idx_reg      <= head_hit ? head_entry.ghr : '0;
            mispredict_reg      <= mispredict;
            recover_ghr_reg     <= mispredict ? recover_next : '0;
            if (head_hit)
                branch_count_reg <= branch_count_reg + CNT_BITS'(1);
            if (mispredict)
                mispredict_count_reg <= mispredict_count_reg + CNT_BITS'(1);
        end
    end

    assign Stall                = q_full;
    assign Resolve_valid        = resolve_valid_reg;
    assign Branch_resolved      = branch_resolved_reg;
    assign Branch_resolved_addr = resolved_addr_reg;
    assign Update_idx           = update_idx_reg;
    assign Mispredict           = mispredict_reg;
    assign Recover_ghr          = recover_ghr_reg;
    assign Branch_count         = branch_count_reg;
    assign Mispredict_count     = mispredict_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit: each vector's expected outputs go
// into a scoreboard when driven and are compared after the following edge.
module tb_branch_resolve_unit;
    localparam int GB = 12;
    localparam int DP = 4;
    localparam int CB = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          Pred_valid = 1'b0, Pred_taken = 1'b0;
    logic [31:0]   Pred_addr = '0;
    logic [GB-1:0] Pred_ghr = '0;
    logic          Exec_valid = 1'b0, Exec_taken = 1'b0;
    logic [31:0]   Exec_addr = '0;
    logic          Stall, Branch_resolved, Resolve_valid, Mispredict;
    logic [31:0]   Branch_resolved_addr;
    logic [GB-1:0] Update_idx, Recover_ghr;
    logic [CB-1:0] Branch_count, Mispredict_count;

    always #5 CLK = ~CLK;

    branch_resolve_unit #(.GHR_BITS(GB), .DEPTH(DP), .CNT_BITS(CB)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Pred_valid           (Pred_valid),
        .Pred_addr            (Pred_addr),
        .Pred_taken           (Pred_taken),
        .Pred_ghr             (Pred_ghr),
        .Exec_valid           (Exec_valid),
        .Exec_addr            (Exec_addr),
        .Exec_taken           (Exec_taken),
        .Stall                (Stall),
        .Branch_resolved      (Branch_resolved),
        .Branch_resolved_addr (Branch_resolved_addr),
        .Resolve_valid        (Resolve_valid),
        .Update_idx           (Update_idx),
        .Mispredict           (Mispredict),
        .Recover_ghr          (Recover_ghr),
        .Branch_count         (Branch_count),
        .Mispredict_count     (Mispredict_count)
    );

    typedef struct {
        logic          pv;
        logic [31:0]   pa;
        logic          pt;
        logic [GB-1:0] pg;
        logic          ev;
        logic [31:0]   ea;
        logic          et;
        logic          stl;
        logic          rv;
        logic          br;
        logic [31:0]   ra;
        logic [GB-1:0] idx;
        logic          mp;
        logic [GB-1:0] rg;
        logic [CB-1:0] bc;
        logic [CB-1:0] mc;
    } vec_t;

    vec_t sb[$];
    vec_t vecs[36];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic pv, logic [31:0] pa, logic pt, logic [GB-1:0] pg,
                                logic ev, logic [31:0] ea, logic et, logic stl,
                                logic rv, logic br, logic [31:0] ra, logic [GB-1:0] idx,
                                logic mp, logic [GB-1:0] rg, logic [CB-1:0] bc, logic [CB-1:0] mc);
        vec_t v;
        v.pv = pv; v.pa = pa; v.pt = pt; v.pg = pg;
        v.ev = ev; v.ea = ea; v.et = et; v.stl = stl;
        v.rv = rv; v.br = br; v.ra = ra; v.idx = idx;
        v.mp = mp; v.rg = rg; v.bc = bc; v.mc = mc;
        return v;
    endfunction

    function automatic vec_t idle(logic stl, logic [CB-1:0] bc, logic [CB-1:0] mc);
        return mk(0, 0, 0, 0, 0, 0, 0, stl, 0, 0, 0, 0, 0, 0, bc, mc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " Stall"}, 32'(Stall), 0);
        chk({tag, " Resolve_valid"}, 32'(Resolve_valid), 0);
        chk({tag, " Branch_resolved"}, 32'(Branch_resolved), 0);
        chk({tag, " addr"}, Branch_resolved_addr, 0);
        chk({tag, " Update_idx"}, 32'(Update_idx), 0);
        chk({tag, " Mispredict"}, 32'(Mispredict), 0);
        chk({tag, " Recover_ghr"}, 32'(Recover_ghr), 0);
        chk({tag, " Branch_count"}, 32'(Branch_count), 0);
        chk({tag, " Mispredict_count"}, 32'(Mispredict_count), 0);
    endtask

    task automatic drive_idle();
        Pred_valid = 0; Pred_addr = 0; Pred_taken = 0; Pred_ghr = 0;
        Exec_valid = 0; Exec_addr = 0; Exec_taken = 0;
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge CLK);
        Pred_valid = v.pv; Pred_addr = v.pa; Pred_taken = v.pt; Pred_ghr = v.pg;
        Exec_valid = v.ev; Exec_addr = v.ea; Exec_taken = v.et;
        #1;
        chk({tag, " Stall"}, 32'(Stall), 32'(v.stl));
        sb.push_back(v);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({tag, " Resolve_valid"}, 32'(Resolve_valid), 32'(e.rv));
        chk({tag, " Branch_resolved"}, 32'(Branch_resolved), 32'(e.br));
        chk({tag, " addr"}, Branch_resolved_addr, e.ra);
        chk({tag, " Update_idx"}, 32'(Update_idx), 32'(e.idx));
        chk({tag, " Mispredict"}, 32'(Mispredict), 32'(e.mp));
        chk({tag, " Recover_ghr"}, 32'(Recover_ghr), 32'(e.rg));
        chk({tag, " Branch_count"}, 32'(Branch_count), 32'(e.bc));
        chk({tag, " Mispredict_count"}, 32'(Mispredict_count), 32'(e.mc));
        $display("%s: pv=%0d pa=%h ev=%0d ea=%h et=%0d -> rv=%0d addr=%h idx=%h mp=%0d rg=%h bc=%0d mc=%0d",
                 tag, v.pv, v.pa, v.ev, v.ea, v.et, Resolve_valid, Branch_resolved_addr,
                 Update_idx, Mispredict, Recover_ghr, Branch_count, Mispredict_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        //             pv  pa     pt pg      ev ea     et stl rv br ra     idx     mp rg      bc mc
        vecs[0]  = mk(1, 'h400, 1, 'h0A5, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      0, 0);
        vecs[1]  = mk(0, 0,     0, 0,     1, 'h400, 1, 0,  1, 1, 'h400, 'h0A5,  0, 0,      1, 0);
        vecs[2]  = mk(1, 'h400, 1, 'h0A5, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      1, 0);
        vecs[3]  = mk(1, 'h404, 1, 'h14B, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      1, 0);
        vecs[4]  = mk(1, 'h408, 1, 'h000, 1, 'h400, 0, 0,  1, 0, 'h400, 'h0A5,  1, 'h14A,  2, 1);
        vecs[5]  = mk(1, 'h40C, 1, 'h001, 1, 'h404, 1, 0,  0, 0, 0,     0,      0, 0,      2, 1);
        vecs[6]  = mk(0, 0,     0, 0,     1, 'h404, 1, 0,  1, 1, 'h404, 0,      1, 'h001,  2, 2);
        vecs[7]  = mk(1, 'h600, 0, 'h0FF, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      2, 2);
        vecs[8]  = mk(0, 0,     0, 0,     1, 'h600, 0, 0,  1, 0, 'h600, 0,      1, 0,      2, 3);
        vecs[9]  = idle(0, 2, 3);
        vecs[10] = mk(0, 0,     0, 0,     1, 'h500, 1, 0,  1, 1, 'h500, 0,      1, 'h001,  2, 4);
        vecs[11] = idle(0, 2, 4);
        vecs[12] = mk(1, 'h700, 1, 'h111, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      2, 4);
        vecs[13] = mk(1, 'h704, 0, 'h222, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      2, 4);
        vecs[14] = mk(1, 'h708, 1, 'h333, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      2, 4);
        vecs[15] = mk(1, 'h70C, 1, 'h444, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      2, 4);
        vecs[16] = mk(1, 'h710, 1, 'h555, 0, 0,     0, 1,  0, 0, 0,     0,      0, 0,      2, 4);
        vecs[17] = mk(1, 'h714, 1, 'h666, 1, 'h700, 1, 1,  1, 1, 'h700, 'h111,  0, 0,      3, 4);
        vecs[18] = idle(1, 3, 4);
        vecs[19] = mk(0, 0,     0, 0,     1, 'h704, 0, 1,  1, 0, 'h704, 'h222,  0, 0,      4, 4);
        vecs[20] = mk(0, 0,     0, 0,     1, 'h708, 1, 0,  1, 1, 'h708, 'h333,  0, 0,      5, 4);
        vecs[21] = mk(0, 0,     0, 0,     1, 'h70C, 1, 0,  1, 1, 'h70C, 'h444,  0, 0,      6, 4);
        vecs[22] = mk(0, 0,     0, 0,     1, 'h714, 1, 0,  1, 1, 'h714, 'h666,  0, 0,      7, 4);
        vecs[23] = mk(0, 0,     0, 0,     1, 'h710, 1, 0,  1, 1, 'h710, 0,      1, 'h001,  7, 5);
        vecs[24] = idle(0, 7, 5);
        vecs[25] = mk(1, 'h800, 1, 'h801, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      7, 5);
        vecs[26] = mk(0, 0,     0, 0,     1, 'h804, 0, 0,  1, 0, 'h804, 0,      1, 0,      7, 6);
        vecs[27] = idle(0, 7, 6);
        vecs[28] = mk(0, 0,     0, 0,     1, 'h800, 1, 0,  1, 1, 'h800, 0,      1, 'h001,  7, 7);
        vecs[29] = idle(0, 7, 7);
        vecs[30] = mk(1, 'h900, 0, 'hFFF, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      7, 7);
        vecs[31] = mk(0, 0,     0, 0,     1, 'h900, 1, 0,  1, 1, 'h900, 'hFFF,  1, 'hFFF,  8, 8);
        vecs[32] = idle(0, 8, 8);
        vecs[33] = mk(1, 'h000, 1, 'h00F, 0, 0,     0, 0,  0, 0, 0,     0,      0, 0,      8, 8);
        vecs[34] = mk(0, 0,     0, 0,     1, 'h000, 1, 0,  1, 1, 'h000, 'h00F,  0, 0,      9, 8);
        vecs[35] = idle(0, 9, 8);

        drive_idle();
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RESET = 1'b1;

        for (int i = 0; i < 36; i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset with three entries in flight.
        step(mk(1, 'hA00, 1, 'h0AA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8), "rst_push0");
        step(mk(1, 'hA04, 1, 'h0AB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8), "rst_push1");
        step(mk(1, 'hA08, 1, 'h0AC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 8), "rst_push2");
        @(negedge CLK);
        drive_idle();
        #2;
        RESET = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge CLK);
        RESET = 1'b1;
        step(idle(0, 0, 0), "post_rst_idle");
        step(mk(0, 0, 0, 0, 1, 'hA00, 1, 0, 1, 1, 'hA00, 0, 1, 'h001, 0, 1), "post_rst_exec");
        step(idle(0, 0, 1), "post_rst_recover");

        // 16 correct push/resolve pairs take the 4-bit Branch_count 0 -> 15 -> 0.
        for (int i = 0; i < 16; i++) begin
            step(mk(1, 32'h0B00 + 32'(4 * i), 1, GB'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    CB'(i), 1), $sformatf("wrap_push%0d", i));
            step(mk(0, 0, 0, 0, 1, 32'h0B00 + 32'(4 * i), 1, 0, 1, 1, 32'h0B00 + 32'(4 * i),
                    GB'(i), 0, 0, CB'((i + 1) % 16), 1), $sformatf("wrap_exec%0d", i));
        end
        step(idle(0, 0, 1), "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
